mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_pkg.sv | 34 +++
 rtl/mul_div_unit_if.sv | 35 +++
 rtl/mul_div_unit_div_u32_step.sv | 39 +++
 rtl/mul_div_unit.sv | 156 +++++++++++++++
 tb/tb_mul_div_unit.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_unit_pkg
// Shared definitions for the RV32M multiply/divide unit: operand width,
// iteration count, the funct3 operation encodings, the controller states,
// and a small two's-complement helper.
// ---------------------------------------------------------------------------
package mul_div_unit_pkg;

  localparam int XLEN    = 32;
  localparam int MD_ITER = 32;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } md_state_e;

  function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
    return (~v) + 32'd1;
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if
// Request/response bundle between the control unit and the multiply/divide
// unit.
//   start  : request pulse, honoured only while busy is low
//   MD_A   : rs1 operand (multiplicand / dividend)
//   MD_B   : rs2 operand (multiplier / divisor)
//   MDsel  : funct3 operation selector
//   MD_out : result, held from the done cycle until the next accepted start
//   busy   : operation in flight
//   done   : one-cycle strobe when MD_out is updated
// master = requester (control unit), slave = execution unit.
// ---------------------------------------------------------------------------
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic            start;
  logic [XLEN-1:0] MD_A;
  logic [XLEN-1:0] MD_B;
  logic [2:0]      MDsel;
  logic [XLEN-1:0] MD_out;
  logic            busy;
  logic            done;

  modport master (
    output start, MD_A, MD_B, MDsel,
    input  MD_out, busy, done
  );

  modport slave (
    input  start, MD_A, MD_B, MDsel,
    output MD_out, busy, done
  );

endinterface

// File: rtl/mul_div_unit_div_u32_step.sv
// ---------------------------------------------------------------------------
// mul_div_unit_div_u32_step
// One combinational restoring-division step on unsigned 32-bit magnitudes.
// The next dividend bit is shifted out of the top of quot into rem; if the
// widened partial remainder reaches the divisor it is reduced and a 1 is
// shifted into the bottom of quot, otherwise a 0.
//   rem, quot, divisor : current partial remainder, dividend/quotient, divisor
//   rem_next, quot_next: values after this step
// A zero divisor always "fits", which yields an all-ones quotient and leaves
// the dividend in rem after 32 steps.
// ---------------------------------------------------------------------------
module mul_div_unit_div_u32_step (
  input  logic [31:0] rem,
  input  logic [31:0] quot,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quot_next
);

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        fits;

  assign shifted = {rem, quot[31]};
  // When the divisor fits, the true difference is below 2^32, so the low
  // 32 bits of the subtraction are exact.
  assign diff    = shifted[31:0] - divisor;
  assign fits    = (shifted >= {1'b0, divisor});

  always_comb begin
    rem_next  = shifted[31:0];
    quot_next = {quot[30:0], 1'b0};
    if (fits) begin
      rem_next  = diff;
      quot_next = {quot[30:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit
// Multi-cycle RV32M execution unit. A start accepted in IDLE latches operand
// magnitudes and result signs, RUN performs 32 shift-add (multiply) or
// restoring shift-subtract (divide) steps, and FIN sign-corrects, selects
// the requested word, registers it into MD_out and pulses done.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, overrides everything else
//   md  : slave side of mul_div_unit_if (start/operands in, result/status out)
// Latency is a fixed 33 cycles from the accepting edge to done.
// ---------------------------------------------------------------------------
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  md
);

  localparam logic [4:0] LAST_ITER = 5'(MD_ITER - 1);

  md_state_e       state, state_next;
  md_sel_e         sel_q;
  md_sel_e         in_sel;
  logic [4:0]      count;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] opb;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] md_out_q;
  logic            done_q;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [32:0]     mul_sum;
  logic [XLEN-1:0] div_rem_next, div_quot_next;
  logic [63:0]     prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;
  logic [XLEN-1:0] result;

  assign in_sel = md_sel_e'(md.MDsel);

  // Operand preparation from the live inputs; only used on the accepting edge.
  always_comb begin
    a_signed = !(in_sel inside {MD_MULHU, MD_DIVU, MD_REMU});
    b_signed = in_sel inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    a_neg    = a_signed && md.MD_A[XLEN-1];
    b_neg    = b_signed && md.MD_B[XLEN-1];
    a_mag    = a_neg ? neg32(md.MD_A) : md.MD_A;
    b_mag    = b_neg ? neg32(md.MD_B) : md.MD_B;
  end

  // Multiply step: acc_hi holds the running upper half, acc_lo holds the
  // unconsumed multiplier bits and collects the low product bits from the top.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);

  mul_div_unit_div_u32_step u_div_step (
    .rem       (acc_hi),
    .quot      (acc_lo),
    .divisor   (opb),
    .rem_next  (div_rem_next),
    .quot_next (div_quot_next)
  );

  // Sign correction and word selection applied in FIN.
  always_comb begin
    prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quot_fix = neg_q ? neg32(acc_lo) : acc_lo;
    rem_fix  = neg_r ? neg32(acc_hi) : acc_hi;
    unique case (sel_q)
      MD_MUL:                       result = prod_fix[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[63:32];
      MD_DIV, MD_DIVU:              result = quot_fix;
      MD_REM, MD_REMU:              result = rem_fix;
      default:                      result = prod_fix[31:0];
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: IDLE waits for start, RUN lasts exactly MD_ITER cycles,
  // FIN is a single cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (md.start) state_next = ST_RUN;
      ST_RUN:  if (count == LAST_ITER) state_next = ST_FIN;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers. The quotient sign is forced positive for a zero
  // divisor so DIV returns all ones regardless of the dividend sign, while
  // the remainder sign follows the dividend so REM returns the original A.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= MD_MUL;
      count    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      md_out_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (md.start) begin
            sel_q  <= in_sel;
            count  <= '0;
            acc_hi <= '0;
            neg_r  <= a_neg;
            if (in_sel[2]) begin
              acc_lo <= a_mag;
              opb    <= b_mag;
              neg_q  <= (a_neg ^ b_neg) && (md.MD_B != '0);
            end else begin
              acc_lo <= b_mag;
              opb    <= a_mag;
              neg_q  <= a_neg ^ b_neg;
            end
          end
        end
        ST_RUN: begin
          count <= count + 5'd1;
          if (sel_q[2]) begin
            acc_hi <= div_rem_next;
            acc_lo <= div_quot_next;
          end else begin
            acc_hi <= mul_sum[32:1];
            acc_lo <= {mul_sum[0], acc_lo[31:1]};
          end
        end
        ST_FIN: begin
          md_out_q <= result;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign md.busy   = (state != ST_IDLE);
  assign md.done   = done_q;
  assign md.MD_out = md_out_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mul_div_unit
// Scoreboard bench for mul_div_unit. Each accepted request pushes its expected
// result and due cycle; a monitor process samples the DUT after every rising
// edge and compares done/busy/MD_out against the queue head. Directed cases
// come from hand-computed constants, random cases from an arithmetic model.
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

  typedef struct {
    logic [31:0] result;
    int          due;
  } exp_t;

  logic           clk;
  logic           rst;
  mul_div_unit_if md_bus ();

  exp_t        scoreboard[$];
  int          cyc;
  int          checks;
  int          errors;
  logic [31:0] exp_out;

  mul_div_unit dut (
    .clk (clk),
    .rst (rst),
    .md  (md_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared comparison routine; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model built from plain signed/unsigned arithmetic.
  function automatic logic [31:0] refModel(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [2:0]  sel);
    int                sa, sbv;
    longint            sp;
    longint unsigned   up;
    logic [63:0]       bits;
    sa  = a;
    sbv = b;
    case (sel)
      3'b000: begin sp = longint'(sa) * longint'(sbv); bits = sp; return bits[31:0]; end
      3'b001: begin sp = longint'(sa) * longint'(sbv); bits = sp; return bits[63:32]; end
      3'b010: begin sp = longint'(sa) * longint'({32'd0, b}); bits = sp; return bits[63:32]; end
      3'b011: begin up = {32'd0, a} * {32'd0, b}; bits = up; return bits[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sbv;
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sbv;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Called at a falling edge while the DUT is idle: issue one request.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] sel, input logic [31:0] exp);
    exp_t e;
    md_bus.start = 1'b1;
    md_bus.MD_A  = a;
    md_bus.MD_B  = b;
    md_bus.MDsel = sel;
    e.result = exp;
    e.due    = cyc + 1 + 33;
    scoreboard.push_back(e);
    @(negedge clk);
    md_bus.start = 1'b0;
    md_bus.MD_A  = $urandom;
    md_bus.MD_B  = $urandom;
  endtask

  // Returns at the falling edge inside the done cycle of the last request.
  task automatic waitIdle();
    int n;
    n = 0;
    while (scoreboard.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (scoreboard.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: %0d results still pending after %0d cycles",
               scoreboard.size(), n);
      scoreboard.delete();
    end
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: after each rising edge compare done, busy and MD_out with the
  // scoreboard head; the result is expected exactly on its due cycle.
  always @(posedge clk) begin
    logic exp_done;
    #1;
    exp_done = 1'b0;
    if (scoreboard.size() > 0 && cyc == scoreboard[0].due) begin
      exp_done = 1'b1;
      exp_out  = scoreboard[0].result;
      scoreboard.delete(0);
    end
    checkOutput("done", {31'd0, md_bus.done}, {31'd0, exp_done});
    checkOutput("busy", {31'd0, md_bus.busy}, {31'd0, (scoreboard.size() > 0)});
    checkOutput(exp_done ? "result" : "md_out_hold", md_bus.MD_out, exp_out);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic [2:0]  sel;
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    exp_out = 32'd0;
    rst          = 1'b1;
    md_bus.start = 1'b0;
    md_bus.MD_A  = 32'd0;
    md_bus.MD_B  = 32'd0;
    md_bus.MDsel = 3'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_md_out", md_bus.MD_out, 32'd0);
    checkOutput("reset_busy", {31'd0, md_bus.busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed arithmetic cases");
    applyStimulus(32'd7,          32'hFFFF_FFFD, 3'b000, 32'hFFFF_FFEB); waitIdle();
    applyStimulus(32'h8000_0000,  32'h8000_0000, 3'b001, 32'h4000_0000); waitIdle();
    applyStimulus(32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'b011, 32'hFFFF_FFFE); waitIdle();
    applyStimulus(32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'b010, 32'hFFFF_FFFF); waitIdle();
    applyStimulus(32'hFFFF_FFF9,  32'd2,         3'b100, 32'hFFFF_FFFD); waitIdle();
    applyStimulus(32'hFFFF_FFF9,  32'd2,         3'b110, 32'hFFFF_FFFF); waitIdle();
    applyStimulus(32'd100,        32'd7,         3'b101, 32'd14);        waitIdle();
    applyStimulus(32'd100,        32'd7,         3'b111, 32'd2);         waitIdle();
    applyStimulus(32'd5,          32'd0,         3'b100, 32'hFFFF_FFFF); waitIdle();
    applyStimulus(32'd5,          32'd0,         3'b111, 32'd5);         waitIdle();
    applyStimulus(32'hFFFF_FFF9,  32'd0,         3'b110, 32'hFFFF_FFF9); waitIdle();
    applyStimulus(32'h8000_0000,  32'hFFFF_FFFF, 3'b100, 32'h8000_0000); waitIdle();
    applyStimulus(32'h8000_0000,  32'hFFFF_FFFF, 3'b110, 32'd0);         waitIdle();
    repeat (2) @(negedge clk);

    $display("[TB] start during RUN is ignored, start in done cycle is taken");
    applyStimulus(32'd7, 32'hFFFF_FFFD, 3'b000, 32'hFFFF_FFEB);
    repeat (9) @(negedge clk);
    md_bus.start = 1'b1;
    md_bus.MD_A  = 32'd3;
    md_bus.MD_B  = 32'd4;
    md_bus.MDsel = 3'b011;
    @(negedge clk);
    md_bus.start = 1'b0;
    waitIdle();
    checkOutput("b2b_in_done_cycle", {31'd0, md_bus.done}, 32'd1);
    applyStimulus(32'd100, 32'd7, 3'b101, 32'd14);
    waitIdle();
    repeat (2) @(negedge clk);

    $display("[TB] reset in the middle of an operation");
    applyStimulus(32'hFFFF_FFF9, 32'd2, 3'b100, 32'hFFFF_FFFD);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    scoreboard.delete();
    exp_out = 32'd0;
    @(negedge clk);
    checkOutput("midrst_md_out", md_bus.MD_out, 32'd0);
    checkOutput("midrst_busy", {31'd0, md_bus.busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, md_bus.done}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(32'd3, 32'd4, 3'b000, 32'd12);
    waitIdle();

    $display("[TB] randomized operations against the reference model");
    for (int i = 0; i < 40; i++) begin
      a   = pickOperand();
      b   = pickOperand();
      sel = 3'($urandom_range(0, 7));
      applyStimulus(a, b, sel, refModel(a, b, sel));
      waitIdle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
